// File: rtl/camera_pkg.sv
// Shared definitions for the camera front end: FSM/phase encodings, coordinate widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package camera_pkg;

    localparam int COL_W = 10;
    localparam int ROW_W = 9;
    localparam int CNT_W = 19;

    // Main FSM state encoding
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t WAIT_VS = 2'd0;
    localparam fsm_state_t FRAME   = 2'd1;
    localparam fsm_state_t PUBLISH = 2'd2;

    // Byte phase within a 4:2:2 group, in camera order
    typedef logic [1:0] phase_t;
    localparam phase_t PH_CB = 2'd0;
    localparam phase_t PH_Y0 = 2'd1;
    localparam phase_t PH_CR = 2'd2;
    localparam phase_t PH_Y1 = 2'd3;

    // Green-pixel counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/yuv422_phase_decoder.sv
// Decodes Cb/Y0/Cr/Y1 byte groups under HREF into pixel strobes with a column count.
// Latency: e_pix and Y/Cb/Cr one cycle after the byte completing the pixel.
// Backpressure: none; the camera cannot be stalled, out-of-window pixels are dropped.
module yuv422_phase_decoder
    import camera_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             row_ok,
    input  logic             href,
    input  logic [7:0]       d,
    output logic [7:0]       y,
    output logic [7:0]       cb,
    output logic [7:0]       cr,
    output logic             e_pix,
    output logic [COL_W-1:0] pix_col,
    output logic             line_end
);

    localparam logic [COL_W-1:0] H_LIM = COL_W'(H_ACTIVE);

    logic             href_q;
    phase_t           phase;
    phase_t           cur_ph;
    logic [7:0]       cb_h;
    logic [7:0]       y0_h;
    logic [7:0]       cr_h;
    logic [COL_W-1:0] col;
    logic             line_pix;
    logic             href_rise;
    logic             href_fall;
    logic             pix_ok;

    assign href_rise = href & ~href_q;
    assign href_fall = ~href & href_q;
    // The first byte of every line is a Cb regardless of where the last line stopped
    assign cur_ph    = href_rise ? PH_CB : phase;
    assign pix_ok    = run & row_ok & (col < H_LIM);
    // Only lines that actually issued a pixel advance the row
    assign line_end  = href_fall & line_pix;

    // Byte capture, phase tracking, pixel issue and column counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_q   <= 1'b0;
            phase    <= PH_CB;
            cb_h     <= '0;
            y0_h     <= '0;
            cr_h     <= '0;
            col      <= '0;
            line_pix <= 1'b0;
            y        <= '0;
            cb       <= '0;
            cr       <= '0;
            e_pix    <= 1'b0;
            pix_col  <= '0;
        end else begin
            href_q <= href;
            e_pix  <= 1'b0;
            if (href_rise) begin
                col      <= '0;
                line_pix <= 1'b0;
            end
            if (href) begin
                phase <= cur_ph + 2'd1;
                case (cur_ph)
                    PH_CB: cb_h <= d;
                    PH_Y0: y0_h <= d;
                    PH_CR: begin
                        cr_h <= d;
                        if (pix_ok) begin
                            y        <= y0_h;
                            cb       <= cb_h;
                            cr       <= d;
                            e_pix    <= 1'b1;
                            pix_col  <= col;
                            col      <= col + 1'b1;
                            line_pix <= 1'b1;
                        end
                    end
                    default: begin
                        if (pix_ok) begin
                            y        <= d;
                            cb       <= cb_h;
                            cr       <= cr_h;
                            e_pix    <= 1'b1;
                            pix_col  <= col;
                            col      <= col + 1'b1;
                            line_pix <= 1'b1;
                        end
                    end
                endcase
            end else begin
                // A group cut short by HREF falling is simply abandoned here
                phase <= PH_CB;
            end
        end
    end

endmodule

// File: rtl/verde_frame_scheduler.sv
// Frame sequencer: feeds the green detector and publishes per-frame bbox/count results.
// Latency: e_pix 1 cycle after byte, verde 1 later, result 1 cycle after PUBLISH entry.
// Backpressure: res_valid/res_ack; an unacked result is overwritten and overrun is set.
module verde_frame_scheduler
    import camera_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int MIN_COUNT = 64
) (
    input  logic             PCLK,
    input  logic             rst_n,
    input  logic             VSYNC,
    input  logic             HREF,
    input  logic [7:0]       D,
    output logic [7:0]       Y,
    output logic [7:0]       Cb,
    output logic [7:0]       Cr,
    output logic             e_pix,
    input  logic             verde,
    output logic             res_valid,
    input  logic             res_ack,
    output logic             found,
    output logic [COL_W-1:0] x_min,
    output logic [COL_W-1:0] x_max,
    output logic [ROW_W-1:0] y_min,
    output logic [ROW_W-1:0] y_max,
    output logic [CNT_W-1:0] count,
    output logic             overrun
);

    localparam logic [ROW_W-1:0] V_LIM   = ROW_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_COUNT);

    fsm_state_t       state;
    logic             vs_q;
    logic             vs_rise;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] pix_col;
    logic             line_end;

    logic             v_vld;
    logic [COL_W-1:0] v_col;
    logic [ROW_W-1:0] v_row;

    logic [CNT_W-1:0] acc_cnt,  n_cnt;
    logic [COL_W-1:0] acc_xmin, n_xmin;
    logic [COL_W-1:0] acc_xmax, n_xmax;
    logic [ROW_W-1:0] acc_ymin, n_ymin;
    logic [ROW_W-1:0] acc_ymax, n_ymax;

    assign vs_rise = VSYNC & ~vs_q;

    yuv422_phase_decoder #(
        .H_ACTIVE (H_ACTIVE)
    ) u_dec (
        .clk      (PCLK),
        .rst_n    (rst_n),
        .run      (state != WAIT_VS),
        .row_ok   (row < V_LIM),
        .href     (HREF),
        .d        (D),
        .y        (Y),
        .cb       (Cb),
        .cr       (Cr),
        .e_pix    (e_pix),
        .pix_col  (pix_col),
        .line_end (line_end)
    );

    // Frame sequencing on registered VSYNC edges
    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            vs_q  <= 1'b0;
            state <= WAIT_VS;
        end else begin
            vs_q <= VSYNC;
            case (state)
                WAIT_VS: if (vs_rise) state <= FRAME;
                FRAME:   if (vs_rise) state <= PUBLISH;
                PUBLISH: state <= FRAME;
                default: state <= WAIT_VS;
            endcase
        end
    end

    // Row count: held at zero outside a frame, advances on each line that produced pixels
    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
        end else if (state != FRAME) begin
            row <= '0;
        end else if (line_end) begin
            row <= row + 1'b1;
        end
    end

    // Delay coordinates one cycle so they line up with the detector's verde
    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            v_vld <= 1'b0;
            v_col <= '0;
            v_row <= '0;
        end else begin
            v_vld <= e_pix;
            v_col <= pix_col;
            v_row <= row;
        end
    end

    // Accumulator next value including any green pixel arriving this cycle
    always_comb begin
        n_cnt  = acc_cnt;
        n_xmin = acc_xmin;
        n_xmax = acc_xmax;
        n_ymin = acc_ymin;
        n_ymax = acc_ymax;
        if (v_vld && verde) begin
            n_cnt = sat_inc(acc_cnt);
            if (v_col < acc_xmin) n_xmin = v_col;
            if (v_col > acc_xmax) n_xmax = v_col;
            if (v_row < acc_ymin) n_ymin = v_row;
            if (v_row > acc_ymax) n_ymax = v_row;
        end
    end

    // Accumulators: cleared when publishing and while waiting for the first frame
    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt  <= '0;
            acc_xmin <= '1;
            acc_xmax <= '0;
            acc_ymin <= '1;
            acc_ymax <= '0;
        end else if (state == PUBLISH || state == WAIT_VS) begin
            acc_cnt  <= '0;
            acc_xmin <= '1;
            acc_xmax <= '0;
            acc_ymin <= '1;
            acc_ymax <= '0;
        end else begin
            acc_cnt  <= n_cnt;
            acc_xmin <= n_xmin;
            acc_xmax <= n_xmax;
            acc_ymin <= n_ymin;
            acc_ymax <= n_ymax;
        end
    end

    // Result registers and valid/ack handshake; PUBLISH uses the drained accumulator value
    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            found     <= 1'b0;
            x_min     <= '1;
            x_max     <= '0;
            y_min     <= '1;
            y_max     <= '0;
            count     <= '0;
            overrun   <= 1'b0;
        end else if (state == PUBLISH) begin
            res_valid <= 1'b1;
            found     <= (n_cnt >= MIN_LIM);
            x_min     <= n_xmin;
            x_max     <= n_xmax;
            y_min     <= n_ymin;
            y_max     <= n_ymax;
            count     <= n_cnt;
            if (res_valid && !res_ack) overrun <= 1'b1;
        end else if (res_ack) begin
            res_valid <= 1'b0;
        end
    end

endmodule
